// File: rtl/gen_fip_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | gen_fip_pkg: shared types for the signed fixed-point sequential mult |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package gen_fip_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PREP = 2'd1,
        MULT = 2'd2,
        FIX  = 2'd3
    } fip_state_e;

endpackage
`default_nettype wire

// File: rtl/gen_fip_sign_abs.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | gen_fip_sign_abs: unsigned magnitude of a two's-complement value     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module gen_fip_sign_abs #(
    parameter int W = 8
) (
    input  logic [W-1:0] i_val,
    output logic [W-1:0] o_mag
);

    // Most-negative input wraps to 2^(W-1), which is exact when read as unsigned.
    always_comb begin
        o_mag = i_val;
        if (i_val[W-1]) begin
            o_mag = (~i_val) + W'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/gen_fip_sign_seq_mult.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | gen_fip_sign_seq_mult: signed fixed-point shift-add multiplier       |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module gen_fip_sign_seq_mult
    import gen_fip_pkg::*;
#(
    parameter int NUM1_INT_W   = 4,
    parameter int NUM1_FRACT_W = 4,
    parameter int NUM2_INT_W   = 4,
    parameter int NUM2_FRACT_W = 4
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   i_start_pls,
    input  logic [NUM1_INT_W+NUM1_FRACT_W-1:0]     i_num1,
    input  logic [NUM2_INT_W+NUM2_FRACT_W-1:0]     i_num2,
    output logic                                   o_busy,
    output logic                                   o_done_pls,
    output logic [NUM1_INT_W+NUM1_FRACT_W+NUM2_INT_W+NUM2_FRACT_W-1:0] o_res
);

    localparam int NUM1_W      = NUM1_INT_W + NUM1_FRACT_W;
    localparam int NUM2_W      = NUM2_INT_W + NUM2_FRACT_W;
    localparam int RES_INT_W   = NUM1_INT_W + NUM2_INT_W;
    localparam int RES_FRACT_W = NUM1_FRACT_W + NUM2_FRACT_W;
    localparam int RES_W       = RES_INT_W + RES_FRACT_W;
    localparam int CNT_W       = $clog2(NUM2_W + 1);

    fip_state_e         r_state_q, r_state_d;
    logic [NUM1_W-1:0]  r_num1_q,  r_num1_d;
    logic [NUM2_W-1:0]  r_num2_q,  r_num2_d;
    logic [RES_W-1:0]   r_mcand_q, r_mcand_d;
    logic [NUM2_W-1:0]  r_mplier_q, r_mplier_d;
    logic               r_sign_q,  r_sign_d;
    logic [RES_W-1:0]   r_acc_q,   r_acc_d;
    logic [CNT_W-1:0]   r_cnt_q,   r_cnt_d;
    logic [RES_W-1:0]   r_res_q,   r_res_d;
    logic               r_done_q,  r_done_d;

    logic [NUM1_W-1:0]  w_mag1;
    logic [NUM2_W-1:0]  w_mag2;
    logic [RES_W-1:0]   w_acc_neg;

    gen_fip_sign_abs #(.W(NUM1_W)) u_abs1 (
        .i_val (r_num1_q),
        .o_mag (w_mag1)
    );

    gen_fip_sign_abs #(.W(NUM2_W)) u_abs2 (
        .i_val (r_num2_q),
        .o_mag (w_mag2)
    );

    assign w_acc_neg = (~r_acc_q) + RES_W'(1);

    always_comb begin
        r_state_d  = r_state_q;
        r_num1_d   = r_num1_q;
        r_num2_d   = r_num2_q;
        r_mcand_d  = r_mcand_q;
        r_mplier_d = r_mplier_q;
        r_sign_d   = r_sign_q;
        r_acc_d    = r_acc_q;
        r_cnt_d    = r_cnt_q;
        r_res_d    = r_res_q;
        r_done_d   = 1'b0;

        case (r_state_q)
            IDLE: begin
                if (i_start_pls) begin
                    r_num1_d  = i_num1;
                    r_num2_d  = i_num2;
                    r_state_d = PREP;
                end
            end
            PREP: begin
                r_mcand_d  = {{(RES_W-NUM1_W){1'b0}}, w_mag1};
                r_mplier_d = w_mag2;
                r_sign_d   = r_num1_q[NUM1_W-1] ^ r_num2_q[NUM2_W-1];
                r_acc_d    = '0;
                r_cnt_d    = CNT_W'(NUM2_W);
                r_state_d  = MULT;
            end
            MULT: begin
                // Multiplicand is pre-shifted each cycle so it always sits at the current bit index.
                if (r_mplier_q[0]) begin
                    r_acc_d = r_acc_q + r_mcand_q;
                end
                r_mcand_d  = r_mcand_q << 1;
                r_mplier_d = r_mplier_q >> 1;
                r_cnt_d    = r_cnt_q - CNT_W'(1);
                if (r_cnt_q == CNT_W'(1)) begin
                    r_state_d = FIX;
                end
            end
            FIX: begin
                r_res_d   = r_sign_q ? w_acc_neg : r_acc_q;
                r_done_d  = 1'b1;
                r_state_d = IDLE;
            end
            default: begin
                r_state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q  <= IDLE;
            r_num1_q   <= '0;
            r_num2_q   <= '0;
            r_mcand_q  <= '0;
            r_mplier_q <= '0;
            r_sign_q   <= 1'b0;
            r_acc_q    <= '0;
            r_cnt_q    <= '0;
            r_res_q    <= '0;
            r_done_q   <= 1'b0;
        end else begin
            r_state_q  <= r_state_d;
            r_num1_q   <= r_num1_d;
            r_num2_q   <= r_num2_d;
            r_mcand_q  <= r_mcand_d;
            r_mplier_q <= r_mplier_d;
            r_sign_q   <= r_sign_d;
            r_acc_q    <= r_acc_d;
            r_cnt_q    <= r_cnt_d;
            r_res_q    <= r_res_d;
            r_done_q   <= r_done_d;
        end
    end

    assign o_busy     = (r_state_q != IDLE);
    assign o_done_pls = r_done_q;
    assign o_res      = r_res_q;

endmodule
`default_nettype wire

// File: tb/tb_gen_fip_sign_seq_mult.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_gen_fip_sign_seq_mult: scoreboard bench for the Q4.4 x Q4.4 mult  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_gen_fip_sign_seq_mult;

    typedef struct {
        logic [15:0] res;
        int          cyc;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        i_start_pls;
    logic [7:0]  i_num1;
    logic [7:0]  i_num2;
    logic        o_busy;
    logic        o_done_pls;
    logic [15:0] o_res;

    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;
    exp_t        sb_q[$];
    logic [15:0] held     = 16'h0000;
    bit          chk_hold = 1'b0;

    gen_fip_sign_seq_mult dut (
        .clk         (clk),
        .rst         (rst),
        .i_start_pls (i_start_pls),
        .i_num1      (i_num1),
        .i_num2      (i_num2),
        .o_busy      (o_busy),
        .o_done_pls  (o_done_pls),
        .o_res       (o_res)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: pops one expectation per done pulse; o_res must hold between pulses.
    always @(negedge clk) begin
        if (o_done_pls) begin
            if (sb_q.size() == 0) begin
                total++; bad++;
                $display("FAIL unexpected_done: cycle %0d res %h, required no pulse", cyc, o_res);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                total++;
                if (o_res !== e.res) begin
                    bad++;
                    $display("FAIL result: got %h required %h", o_res, e.res);
                end
                total++;
                if (cyc != e.cyc) begin
                    bad++;
                    $display("FAIL done_cycle: got %0d required %0d", cyc, e.cyc);
                end
            end
            held = o_res;
        end else if (chk_hold) begin
            total++;
            if (o_res !== held) begin
                bad++;
                $display("FAIL res_hold: got %h required %h", o_res, held);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endtask

    // Drive a start in the current cycle (caller is at a negedge).
    task automatic issue_now(input logic [7:0] a, input logic [7:0] b,
                             input logic [15:0] exp_res, input bit push);
        exp_t e;
        i_start_pls = 1'b1;
        i_num1      = a;
        i_num2      = b;
        @(posedge clk);
        #1;
        if (push) begin
            e.res = exp_res;
            e.cyc = cyc + 10;
            sb_q.push_back(e);
        end
        i_start_pls = 1'b0;
    endtask

    task automatic do_start(input logic [7:0] a, input logic [7:0] b,
                            input logic [15:0] exp_res, input bit push);
        @(negedge clk);
        issue_now(a, b, exp_res, push);
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && sb_q.size() != 0; i++) @(negedge clk);
        if (sb_q.size() != 0) begin
            total++; bad++;
            $display("FAIL drain_timeout: %0d results pending, required 0", sb_q.size());
            sb_q.delete();
        end
        @(negedge clk);
    endtask

    task automatic wait_done(output int when);
        when = -1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (o_done_pls) begin
                when = cyc;
                break;
            end
        end
        if (when < 0) begin
            total++; bad++;
            $display("FAIL wait_done_timeout: got no pulse, required one within 30 cycles");
        end
    endtask

    initial begin
        int d0, d1, d2;
        rst         = 1'b1;
        i_start_pls = 1'b0;
        i_num1      = 8'h00;
        i_num2      = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_busy", {31'd0, o_busy}, 32'd0);
        chk("reset_done", {31'd0, o_done_pls}, 32'd0);
        chk("reset_res", {16'd0, o_res}, 32'd0);
        rst      = 1'b0;
        chk_hold = 1'b1;

        // Directed products, one at a time
        do_start(8'h18, 8'h20, 16'h0300, 1'b1);
        @(negedge clk);
        chk("busy_during_op", {31'd0, o_busy}, 32'd1);
        drain();
        do_start(8'hE8, 8'h20, 16'hFD00, 1'b1); drain();
        do_start(8'hE8, 8'hE0, 16'h0300, 1'b1); drain();
        do_start(8'h80, 8'h80, 16'h4000, 1'b1); drain();
        do_start(8'h7F, 8'h80, 16'hC080, 1'b1); drain();
        do_start(8'h00, 8'h80, 16'h0000, 1'b1); drain();
        do_start(8'h7F, 8'h7F, 16'h3F01, 1'b1); drain();
        do_start(8'hFF, 8'h01, 16'hFFFF, 1'b1); drain();
        do_start(8'h10, 8'hF0, 16'hFF00, 1'b1); drain();
        chk("idle_after_done", {31'd0, o_busy}, 32'd0);

        // Second start while busy must be dropped
        do_start(8'h18, 8'h20, 16'h0300, 1'b1);
        @(negedge clk);
        do_start(8'h7F, 8'h7F, 16'h0000, 1'b0);
        drain();
        repeat (15) @(negedge clk);

        // Reset mid-operation aborts with no pulse
        do_start(8'h80, 8'h80, 16'h4000, 1'b1);
        repeat (3) @(negedge clk);
        chk_hold = 1'b0;
        rst      = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_busy", {31'd0, o_busy}, 32'd0);
        chk("abort_res", {16'd0, o_res}, 32'd0);
        sb_q.delete();
        held     = 16'h0000;
        chk_hold = 1'b1;
        repeat (15) @(negedge clk);
        do_start(8'hE8, 8'h20, 16'hFD00, 1'b1);
        drain();

        // Back-to-back: each start issued the cycle following its predecessor's done
        do_start(8'h18, 8'h20, 16'h0300, 1'b1);
        wait_done(d0);
        issue_now(8'h80, 8'h80, 16'h4000, 1'b1);
        wait_done(d1);
        issue_now(8'h7F, 8'h80, 16'hC080, 1'b1);
        wait_done(d2);
        chk("b2b_spacing_1", d1 - d0, 32'd11);
        chk("b2b_spacing_2", d2 - d1, 32'd11);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, required completion");
        $fatal(1);
    end

endmodule
`default_nettype wire
